// File: rtl/oam_dma_ctrl.sv
// Sprite OAM DMA engine: on a CPU write to the DMA register, halts the CPU and
// copies one 256-byte page to the PPU OAM data port, one read/write pair per
// two cycles, aligned so that every read lands on an even (par==0) cycle.
module oam_dma_ctrl #(
    parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
    parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
    input  logic        clk_ph1,
    input  logic        rst,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_data_out,
    input  logic        cpu_R_nW,
    input  logic [7:0]  mem_data_in,
    output logic        cpu_halt,
    output logic        dma_active,
    output logic [15:0] dma_addr,
    output logic [7:0]  dma_data_out,
    output logic        dma_R_nW
);

    localparam int unsigned XFER_LEN = 256;
    localparam int unsigned IDX_W    = 8;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(XFER_LEN - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HALT  = 3'd1,
        ALIGN = 3'd2,
        READ  = 3'd3,
        WRITE = 3'd4
    } state_t;

    state_t           state;
    logic [7:0]       page;
    logic [IDX_W-1:0] idx;
    logic             par;
    logic             trigger_c;

    // A CPU write to the DMA register starts a transfer (only looked at in IDLE).
    assign trigger_c = (cpu_addr == DMA_REG_ADDR) && !cpu_R_nW;

    // Sequencer; outputs are loaded together with the state they belong to, so
    // they always equal the decode of the current state. dma_data_out doubles
    // as the read-data latch: it captures the READ byte and presents it in WRITE.
    always_ff @(posedge clk_ph1) begin
        if (!rst) begin
            state        <= IDLE;
            page         <= 8'h00;
            idx          <= '0;
            par          <= 1'b0;
            cpu_halt     <= 1'b0;
            dma_active   <= 1'b0;
            dma_addr     <= 16'h0000;
            dma_data_out <= 8'h00;
            dma_R_nW     <= 1'b1;
        end else begin
            par <= ~par;
            case (state)
                IDLE: begin
                    if (trigger_c) begin
                        state        <= HALT;
                        page         <= cpu_data_out;
                        idx          <= '0;
                        cpu_halt     <= 1'b1;
                        dma_active   <= 1'b1;
                        dma_addr     <= OAM_DATA_ADDR;
                        dma_data_out <= 8'h00;
                        dma_R_nW     <= 1'b1;
                    end
                end
                HALT: begin
                    // Reads must fall on par==0 cycles; insert ALIGN if the next one is odd.
                    if (par) begin
                        state    <= READ;
                        dma_addr <= {page, idx};
                    end else begin
                        state    <= ALIGN;
                        dma_addr <= OAM_DATA_ADDR;
                    end
                end
                ALIGN: begin
                    state    <= READ;
                    dma_addr <= {page, idx};
                end
                READ: begin
                    state        <= WRITE;
                    dma_addr     <= OAM_DATA_ADDR;
                    dma_data_out <= mem_data_in;
                    dma_R_nW     <= 1'b0;
                end
                WRITE: begin
                    dma_data_out <= 8'h00;
                    dma_R_nW     <= 1'b1;
                    if (idx == LAST_IDX) begin
                        state      <= IDLE;
                        cpu_halt   <= 1'b0;
                        dma_active <= 1'b0;
                        dma_addr   <= 16'h0000;
                    end else begin
                        state    <= READ;
                        idx      <= idx + IDX_W'(1);
                        dma_addr <= {page, idx + IDX_W'(1)};
                    end
                end
                default: begin
                    state        <= IDLE;
                    cpu_halt     <= 1'b0;
                    dma_active   <= 1'b0;
                    dma_addr     <= 16'h0000;
                    dma_data_out <= 8'h00;
                    dma_R_nW     <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Self-checking bench for oam_dma_ctrl: random CPU traffic and memory contents,
// expected bus activity derived from cycle offsets after each trigger.
module tb_oam_dma_ctrl;

    logic        clk_ph1 = 1'b0;
    logic        rst;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_data_out;
    logic        cpu_R_nW;
    logic [7:0]  mem_data_in;
    logic        cpu_halt;
    logic        dma_active;
    logic [15:0] dma_addr;
    logic [7:0]  dma_data_out;
    logic        dma_R_nW;

    int          checks = 0;
    int          passed = 0;
    int unsigned cyc    = 0;
    logic [7:0]  key    = 8'h00;

    localparam logic [26:0] IDLE_BUS = {1'b0, 1'b0, 16'h0000, 8'h00, 1'b1};

    oam_dma_ctrl dut (
        .clk_ph1      (clk_ph1),
        .rst          (rst),
        .cpu_addr     (cpu_addr),
        .cpu_data_out (cpu_data_out),
        .cpu_R_nW     (cpu_R_nW),
        .mem_data_in  (mem_data_in),
        .cpu_halt     (cpu_halt),
        .dma_active   (dma_active),
        .dma_addr     (dma_addr),
        .dma_data_out (dma_data_out),
        .dma_R_nW     (dma_R_nW)
    );

    always #5 clk_ph1 = ~clk_ph1;

    // Memory model: byte at any address is its low byte XOR a per-test key.
    assign mem_data_in = dma_addr[7:0] ^ key;

    // Cycle index since reset; its LSB is the parity of the current cycle.
    always @(posedge clk_ph1) begin
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    wire [26:0] bus = {cpu_halt, dma_active, dma_addr, dma_data_out, dma_R_nW};

    // Expected bus k cycles after the trigger cycle, h = parity of the HALT cycle.
    function automatic logic [26:0] exp_bus(int k, bit h, logic [7:0] pg);
        int         first;
        int         j;
        logic [7:0] ix;
        first = h ? 2 : 3;
        if (k < 1 || k > first + 511) return IDLE_BUS;
        if (k < first) return {2'b11, 16'h2004, 8'h00, 1'b1};
        j  = k - first;
        ix = 8'(j / 2);
        if (j % 2 == 0) return {2'b11, pg, ix, 8'h00, 1'b1};
        return {2'b11, 16'h2004, ix ^ key, 1'b0};
    endfunction

    task automatic tick();
        @(posedge clk_ph1);
        #1;
    endtask

    // Random CPU traffic that never writes the DMA register.
    task automatic idle_traffic();
        cpu_addr     = 16'($urandom);
        cpu_data_out = 8'($urandom);
        cpu_R_nW     = 1'($urandom);
        if (cpu_addr == 16'h4014 && !cpu_R_nW) cpu_R_nW = 1'b1;
    endtask

    // Random CPU traffic that often writes the DMA register (must be ignored while busy).
    task automatic busy_traffic();
        cpu_addr     = 16'($urandom);
        cpu_data_out = 8'($urandom);
        cpu_R_nW     = 1'($urandom);
        if ($urandom_range(0, 3) == 0) begin
            cpu_addr = 16'h4014;
            cpu_R_nW = 1'b0;
        end
    endtask

    // Full transfer: idle cycles, optional parity alignment, trigger, 513/514 checked cycles.
    task automatic test_transfer(input logic [7:0] pg, input int min_idle, input int want_h,
                                 input string tag);
        bit h;
        int last;
        int stall;
        for (int i = 0; i < min_idle; i++) begin
            idle_traffic();
            tick();
            checks++;
            if (bus !== IDLE_BUS) $display("FAIL %s idle: bus=%h expected %h", tag, bus, IDLE_BUS);
            else passed++;
        end
        if (want_h != 2 && int'(!cyc[0]) != want_h) begin
            idle_traffic();
            tick();
            checks++;
            if (bus !== IDLE_BUS) $display("FAIL %s align-idle: bus=%h expected %h", tag, bus, IDLE_BUS);
            else passed++;
        end
        h            = !cyc[0];
        cpu_addr     = 16'h4014;
        cpu_R_nW     = 1'b0;
        cpu_data_out = pg;
        last         = h ? 513 : 514;
        stall        = 0;
        for (int k = 1; k <= last + 1; k++) begin
            tick();
            checks++;
            if (bus !== exp_bus(k, h, pg))
                $display("FAIL %s cycle %0d: bus=%h expected %h", tag, k, bus, exp_bus(k, h, pg));
            else passed++;
            if (cpu_halt) stall++;
            if (k <= last) busy_traffic();
            else           idle_traffic();
        end
        checks++;
        if (stall != last) $display("FAIL %s stall: got %0d cycles expected %0d", tag, stall, last);
        else passed++;
    endtask

    task automatic test_reset();
        rst          = 1'b0;
        cpu_addr     = 16'h4014;
        cpu_R_nW     = 1'b0;
        cpu_data_out = 8'($urandom);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus !== IDLE_BUS) $display("FAIL reset %0d: bus=%h expected %h", i, bus, IDLE_BUS);
            else passed++;
        end
        rst = 1'b1;
        idle_traffic();
        tick();
        checks++;
        if (bus !== IDLE_BUS) $display("FAIL reset_release: bus=%h expected %h", bus, IDLE_BUS);
        else passed++;
    endtask

    task automatic test_no_false_trigger();
        for (int i = 0; i < 40; i++) begin
            idle_traffic();
            if (i % 3 == 0) begin
                cpu_addr = 16'h4014;
                cpu_R_nW = 1'b1;
            end else if (i % 3 == 1) begin
                cpu_addr = 16'h4015;
                cpu_R_nW = 1'b0;
            end
            tick();
            checks++;
            if (bus !== IDLE_BUS) $display("FAIL no_false_trigger %0d: bus=%h expected %h", i, bus, IDLE_BUS);
            else passed++;
        end
    endtask

    task automatic test_even_align();
        key = 8'($urandom);
        test_transfer(8'h02, 1, 1, "even_align");
    endtask

    task automatic test_odd_align();
        key = 8'($urandom);
        test_transfer(8'h02, 1, 0, "odd_align");
    endtask

    task automatic test_data_integrity();
        key = 8'hA5;
        test_transfer(8'h02, 2, 2, "data_integrity");
    endtask

    task automatic test_reset_mid();
        bit         h;
        logic [7:0] pg;
        key          = 8'($urandom);
        pg           = 8'($urandom);
        idle_traffic();
        tick();
        h            = !cyc[0];
        cpu_addr     = 16'h4014;
        cpu_R_nW     = 1'b0;
        cpu_data_out = pg;
        for (int k = 1; k <= 100; k++) begin
            tick();
            checks++;
            if (bus !== exp_bus(k, h, pg))
                $display("FAIL reset_mid cycle %0d: bus=%h expected %h", k, bus, exp_bus(k, h, pg));
            else passed++;
            busy_traffic();
            if (k == 100) rst = 1'b0;
        end
        tick();
        checks++;
        if (bus !== IDLE_BUS) $display("FAIL reset_mid reset: bus=%h expected %h", bus, IDLE_BUS);
        else passed++;
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            idle_traffic();
            tick();
            checks++;
            if (bus !== IDLE_BUS) $display("FAIL reset_mid no_resume %0d: bus=%h expected %h", i, bus, IDLE_BUS);
            else passed++;
        end
        test_transfer(8'h07, 0, 2, "after_reset");
    endtask

    task automatic test_back_to_back();
        key = 8'($urandom);
        test_transfer(8'hFF, 2, 2, "page_wrap");
        test_transfer(8'h03, 0, 2, "back_to_back");
    endtask

    task automatic test_random();
        for (int n = 0; n < 3; n++) begin
            key = 8'($urandom);
            test_transfer(8'($urandom), int'($urandom_range(0, 5)), 2, "random");
        end
    endtask

    initial begin
        rst          = 1'b0;
        cpu_addr     = 16'h0000;
        cpu_data_out = 8'h00;
        cpu_R_nW     = 1'b1;
        test_reset();
        test_no_false_trigger();
        test_even_align();
        test_odd_align();
        test_data_integrity();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/oam_dma_ctrl.md
Name: oam_dma_ctrl

Overview:
- Sprite DMA engine on the CPU address/data bus, directly downstream of the CPU core.
- A CPU write to $4014 stalls the CPU and copies 256 bytes from page $XX00–$XXFF to the PPU OAM data port $2004.
- Takes bus mastership for 513 or 514 cycles, then releases it.
- The top-level bus mux selects DMA address, data and R_nW whenever dma_active=1.

Parameters:
- DMA_REG_ADDR, 16'h4014, CPU write address that triggers DMA.
- OAM_DATA_ADDR, 16'h2004, destination address for every DMA write.
- XFER_LEN, 256, bytes per transfer. Fixed at 256; the index is 8 bits.

Ports:
- clk_ph1 input 1: the only clock. All state changes on its rising edge.
- rst input 1: synchronous reset, active-low. Sampled on the clk_ph1 rising edge; 0 = reset.
- cpu_addr input 16: CPU Addr_bus.
- cpu_data_out input 8: CPU Data_bus_out.
- cpu_R_nW input 1: CPU R_nW (0 = write).
- mem_data_in input 8: shared read data bus (Data_bus_in).
- cpu_halt output 1: 1 stalls the CPU (CPU holds all state).
- dma_active output 1: bus mux select, 1 = DMA owns the bus.
- dma_addr output 16: DMA address.
- dma_data_out output 8: DMA write data.
- dma_R_nW output 1: DMA read/write (0 = write).

Behaviour:
- Parity flop `par`:
  - Reset to 0; toggles every clk_ph1 cycle while rst=1.
  - Defines the "even" cycles on which DMA reads occur.
- States: IDLE, HALT, ALIGN, READ, WRITE.
  - state, page[7:0] and idx[7:0] are registered.
  - latch[7:0] is registered.
  - Outputs are decoded combinationally from the registers.
- Reset (rst=0 at a clock edge), applied from any state, including mid-transfer:
  - state=IDLE, page=0, idx=0, latch=0, par=0.
  - Outputs: cpu_halt=0, dma_active=0, dma_addr=16'h0000, dma_data_out=8'h00, dma_R_nW=1.
- IDLE:
  - Outputs as at reset.
  - Trigger: cpu_addr==DMA_REG_ADDR and cpu_R_nW==0 on the current cycle.
  - On trigger: page<=cpu_data_out, idx<=0, next state HALT.
  - A read of $4014 does not trigger.
- HALT (1 cycle):
  - cpu_halt=1, dma_active=1, dma_addr=OAM_DATA_ADDR, dma_R_nW=1 (dummy read, no side effect required).
  - Next state READ if par==1 in this cycle, else ALIGN.
- ALIGN (1 cycle):
  - Same outputs as HALT.
  - Next state READ.
- READ:
  - dma_addr={page,idx}, dma_R_nW=1.
  - latch<=mem_data_in at the end of the cycle.
  - Next state WRITE.
- WRITE:
  - dma_addr=OAM_DATA_ADDR, dma_R_nW=0, dma_data_out=latch.
  - If idx==8'hFF: next state IDLE.
  - Otherwise: idx<=idx+1, next state READ.
- cpu_halt and dma_active are 1 in every non-IDLE state.
- dma_data_out is 8'h00 outside WRITE.
- Stall length, counted from the cycle after the trigger write to the last WRITE inclusive:
  - 513 cycles when the HALT cycle has par==1.
  - 514 cycles when the HALT cycle has par==0.
  - The CPU resumes on the next cycle.
- READ cycles always have par==0.
- The source address does not carry into the page byte; idx wraps only at termination.
- page=$FF is legal: reads $FF00–$FFFF.
- Writes to DMA_REG_ADDR while not IDLE are ignored. They cannot occur while the CPU is halted, but the block must not act on them.
- Back-to-back transfers:
  - After returning to IDLE, a new trigger may occur on the first IDLE cycle.
  - It is handled identically.
- Reset released mid-transfer: the block stays IDLE until a new trigger; no partial resume.

Test Plan:
- Even-align: reset, trigger $4014←$02 so that HALT has par==1.
  - Response: cpu_halt high exactly 513 cycles.
  - Bus sequence: read $0200, write $2004, read $0201, … read $02FF, write $2004.
- Odd-align: same as above but trigger one cycle later.
  - Response: 514 stall cycles; one ALIGN cycle with dma_addr=$2004, dma_R_nW=1.
- Data integrity: memory model returns (addr[7:0]^8'hA5).
  - Response: the 256 write cycles present 8'hA5, 8'hA4, …, 8'h5A in order.
- No false trigger:
  - CPU read of $4014 → no DMA.
  - CPU write to $4015 → no DMA.
  - dma_active stays 0.
- Reset mid-op: assert rst=0 on the 100th DMA cycle.
  - Response: next cycle all outputs at reset values.
  - Later trigger $4014←$07 runs a full transfer from $0700.
- Page wrap/back-to-back:
  - Trigger $4014←$FF.
  - Response: last read at $FFFF, no access to $0000.
  - An immediate re-trigger $4014←$03 on the first IDLE cycle starts a new transfer from $0300.
